pio_pulse_out: RTL and testbench

- Parametrised Avalon-MM slave output port; successor to the single-bit radio chip-enable PIO.
- Drives WIDTH output lines, with atomic bit set/clear and a hardware-timed pulse mode.
- Pulse mode raises selected bits for an exact cycle count, e.g. the nRF2401 CE ≥10 µs strobe, so software timing loops are not needed.
- Sits on the Nios system bus; out_port goes to pins; irq goes to the interrupt controller.

---
 rtl/pio_pkg.sv | 27 ++
 rtl/pio_pulse_timer.sv | 54 +++++
 rtl/pio_pulse_out.sv | 126 ++++++++++++
 tb/tb_pio_pulse_out.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the pulse-capable PIO: register map, status bit
// positions, timer state encoding and the pulse-length clamp.
`timescale 1ns/1ps
package pio_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_SET       = 3'd1;
    localparam logic [2:0] ADDR_CLR       = 3'd2;
    localparam logic [2:0] ADDR_PULSE     = 3'd3;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;
    localparam logic [2:0] ADDR_IRQ_EN    = 3'd6;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic {
        TIMER_IDLE,
        TIMER_RUN
    } timer_state_e;

    // A programmed length of zero still produces a one-cycle pulse.
    function automatic logic [31:0] clamp_pulse_len(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/pio_pulse_timer.sv
// Down-counter that times one pulse window; a load while running restarts it
// and suppresses the expire strobe of that same cycle.
`timescale 1ns/1ps
module pio_pulse_timer
    import pio_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             expire
);

    timer_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             last_cycle;

    assign last_cycle = (count_q == CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= TIMER_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (load) begin
            state_d = TIMER_RUN;
            count_d = len;
        end else if (state_q == TIMER_RUN) begin
            if (last_cycle) begin
                state_d = TIMER_IDLE;
                count_d = '0;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        busy   = (state_q == TIMER_RUN);
        expire = (state_q == TIMER_RUN) && last_cycle && !load;
    end

endmodule

// File: rtl/pio_pulse_out.sv
// Avalon-MM output port with atomic set/clear and hardware-timed pulses that
// raise selected lines for an exact number of clock cycles.
`timescale 1ns/1ps
module pio_pulse_out
    import pio_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               CNT_W         = 16,
    parameter int               PULSE_DEFAULT = 500,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] pulse_len_q, pulse_len_d;
    logic             done_q, done_d;
    logic             irq_en_q, irq_en_d;

    logic             we;
    logic [WIDTH-1:0] wd;
    logic             pulse_load;
    logic [CNT_W-1:0] load_len;
    logic             busy;
    logic             expire;
    logic             unused_wdata;

    assign we           = chipselect && !write_n;
    assign wd           = writedata[WIDTH-1:0];
    assign pulse_load   = we && (address == ADDR_PULSE) && (|wd);
    assign load_len     = CNT_W'(clamp_pulse_len(32'(pulse_len_q)));
    assign unused_wdata = ^writedata;

    pio_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pulse_load),
        .len     (load_len),
        .busy    (busy),
        .expire  (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= RESET_VALUE;
            mask_q      <= '0;
            pulse_len_q <= CNT_W'(PULSE_DEFAULT);
            done_q      <= 1'b0;
            irq_en_q    <= 1'b0;
        end else begin
            data_q      <= data_d;
            mask_q      <= mask_d;
            pulse_len_q <= pulse_len_d;
            done_q      <= done_d;
            irq_en_q    <= irq_en_d;
        end
    end

    // Expiry is folded in before the CPU write so written bits take precedence.
    always_comb begin
        data_d      = data_q;
        mask_d      = mask_q;
        pulse_len_d = pulse_len_q;
        done_d      = done_q;
        irq_en_d    = irq_en_q;

        if (expire) begin
            data_d = data_d & ~mask_q;
            mask_d = '0;
        end

        if (we) begin
            case (address)
                ADDR_DATA:      data_d = wd;
                ADDR_SET:       data_d = data_d | wd;
                ADDR_CLR:       data_d = data_d & ~wd;
                ADDR_PULSE: begin
                    data_d = data_d | wd;
                    mask_d = mask_d | wd;
                end
                ADDR_PULSE_LEN: pulse_len_d = writedata[CNT_W-1:0];
                ADDR_STATUS: begin
                    if (writedata[STATUS_DONE_BIT]) begin
                        done_d = 1'b0;
                    end
                end
                ADDR_IRQ_EN:    irq_en_d = writedata[0];
                default: ;
            endcase
        end

        if (expire) begin
            done_d = 1'b1;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:      readdata = 32'(data_q);
            ADDR_PULSE:     readdata = 32'(mask_q);
            ADDR_PULSE_LEN: readdata = 32'(pulse_len_q);
            ADDR_STATUS: begin
                readdata[STATUS_BUSY_BIT] = busy;
                readdata[STATUS_DONE_BIT] = done_q;
            end
            ADDR_IRQ_EN:    readdata = {31'd0, irq_en_q};
            default:        readdata = 32'd0;
        endcase
    end

    assign out_port = data_q;
    assign irq      = done_q && irq_en_q;

endmodule

// File: tb/tb_pio_pulse_out.sv
// Self-checking bench for pio_pulse_out: directed scenarios plus a randomized
// phase, all compared against a time-based reference model.
`timescale 1ns/1ps
module tb_pio_pulse_out;

    localparam int         WIDTH         = 8;
    localparam int         CNT_W         = 16;
    localparam int         PULSE_DEFAULT = 500;
    localparam logic [7:0] RESET_VALUE   = 8'h00;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [2:0]  address    = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        irq;

    always #5 clk = ~clk;

    pio_pulse_out #(
        .WIDTH         (WIDTH),
        .CNT_W         (CNT_W),
        .PULSE_DEFAULT (PULSE_DEFAULT),
        .RESET_VALUE   (RESET_VALUE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    int check_count = 0;
    int pass_count  = 0;
    int cyc         = 0;

    // Reference model: a pulse is described by the absolute edge number at
    // which it ends, rather than by a counter.
    logic [7:0]  m_data;
    logic [7:0]  m_mask;
    logic [15:0] m_len;
    logic        m_busy;
    logic        m_done;
    logic        m_irq_en;
    int          m_end;

    logic [7:0]  obs_out;
    logic [31:0] obs_read;
    logic        obs_irq;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'd0, m_data};
            3'd3:    return {24'd0, m_mask};
            3'd4:    return {16'd0, m_len};
            3'd5:    return {30'd0, m_done, m_busy};
            3'd6:    return {31'd0, m_irq_en};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_data   = RESET_VALUE;
        m_mask   = 8'd0;
        m_len    = 16'(PULSE_DEFAULT);
        m_busy   = 1'b0;
        m_done   = 1'b0;
        m_irq_en = 1'b0;
        m_end    = 0;
    endtask

    task automatic model_edge(input bit cs, input bit wn, input logic [2:0] a,
                              input logic [31:0] wdata);
        bit         we;
        bit         retrig;
        bit         ending;
        logic [7:0] w;
        we     = cs && !wn;
        w      = wdata[7:0];
        retrig = we && (a == 3'd3) && (w != 8'd0);
        ending = m_busy && (cyc == m_end) && !retrig;
        if (ending) begin
            m_data = m_data & ~m_mask;
            m_mask = 8'd0;
            m_busy = 1'b0;
        end
        if (we) begin
            case (a)
                3'd0: m_data = w;
                3'd1: m_data = m_data | w;
                3'd2: m_data = m_data & ~w;
                3'd3: if (retrig) begin
                    m_data = m_data | w;
                    m_mask = m_mask | w;
                    m_busy = 1'b1;
                    m_end  = cyc + ((m_len == 16'd0) ? 1 : int'(m_len));
                end
                3'd4: m_len = wdata[15:0];
                3'd5: if (wdata[1]) m_done = 1'b0;
                3'd6: m_irq_en = wdata[0];
                default: ;
            endcase
        end
        if (ending) m_done = 1'b1;
    endtask

    // One bus cycle: drive, check outputs before the edge, then step the model.
    task automatic applyStimulus(input bit cs, input bit wn, input logic [2:0] a,
                                 input logic [31:0] wdata);
        @(negedge clk);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wdata;
        #1;
        obs_out  = out_port;
        obs_read = readdata;
        obs_irq  = irq;
        checkOutput("out_port", 32'(out_port), 32'(m_data));
        checkOutput("irq", 32'(irq), 32'(m_done & m_irq_en));
        checkOutput($sformatf("readdata@%0d", a), readdata, model_read(a));
        @(posedge clk);
        cyc++;
        model_edge(cs, wn, a, wdata);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [31:0] wdata);
        applyStimulus(1'b1, 1'b0, a, wdata);
    endtask

    task automatic read_reg(input logic [2:0] a);
        applyStimulus(1'b1, 1'b1, a, 32'd0);
    endtask

    task automatic idle_cycle();
        applyStimulus(1'b0, 1'b1, 3'd0, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         high0;
        int         high1;
        int         busy_seen;
        logic [31:0] wdata;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n    = 1'b1;
        chipselect = 1'b1;
        address    = 3'd4;
        #1;
        checkOutput("reset_out_port", 32'(out_port), 32'h00);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        checkOutput("reset_pulse_len", readdata, 32'd500);
        chipselect = 1'b0;

        // DATA write and readback
        write_reg(3'd0, 32'h0000_00A5);
        read_reg(3'd0);
        checkOutput("data_a5_port", 32'(obs_out), 32'hA5);
        checkOutput("data_a5_read", obs_read, 32'hA5);

        // SET then CLR, both reading back as zero
        write_reg(3'd0, 32'h0000_00A0);
        write_reg(3'd1, 32'h0000_000F);
        read_reg(3'd1);
        checkOutput("set_port", 32'(obs_out), 32'hAF);
        checkOutput("set_read", obs_read, 32'd0);
        write_reg(3'd2, 32'h0000_0005);
        read_reg(3'd2);
        checkOutput("clr_port", 32'(obs_out), 32'hAA);
        checkOutput("clr_read", obs_read, 32'd0);

        // Three-cycle pulse with interrupt
        write_reg(3'd6, 32'd1);
        write_reg(3'd4, 32'd3);
        write_reg(3'd0, 32'd0);
        write_reg(3'd3, 32'h01);
        high0     = 0;
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            read_reg(3'd5);
            if (obs_out[0]) high0++;
            if (obs_read[0]) busy_seen++;
        end
        checkOutput("pulse3_width", 32'(high0), 32'd3);
        checkOutput("pulse3_busy", 32'(busy_seen), 32'd3);
        checkOutput("pulse3_status", obs_read, 32'h2);
        checkOutput("pulse3_irq", 32'(obs_irq), 32'd1);
        write_reg(3'd5, 32'h2);
        idle_cycle();
        checkOutput("irq_cleared", 32'(obs_irq), 32'd0);

        // Retrigger two cycles into a four-cycle pulse
        write_reg(3'd4, 32'd4);
        write_reg(3'd3, 32'h01);
        high0 = 0;
        high1 = 0;
        idle_cycle();
        if (obs_out[0]) high0++;
        if (obs_out[1]) high1++;
        write_reg(3'd3, 32'h02);
        if (obs_out[0]) high0++;
        if (obs_out[1]) high1++;
        for (int i = 0; i < 12; i++) begin
            idle_cycle();
            if (obs_out[0]) high0++;
            if (obs_out[1]) high1++;
        end
        checkOutput("retrig_bit0_width", 32'(high0), 32'd6);
        checkOutput("retrig_bit1_width", 32'(high1), 32'd4);
        read_reg(3'd5);
        checkOutput("retrig_status", obs_read, 32'h2);
        write_reg(3'd5, 32'h2);

        // DATA write landing on the expiry edge
        write_reg(3'd4, 32'd3);
        write_reg(3'd3, 32'h01);
        idle_cycle();
        idle_cycle();
        write_reg(3'd0, 32'hFF);
        read_reg(3'd5);
        checkOutput("collide_port", 32'(obs_out), 32'hFF);
        checkOutput("collide_status", obs_read, 32'h2);
        write_reg(3'd5, 32'h2);

        // Zero length behaves as one cycle
        write_reg(3'd0, 32'd0);
        write_reg(3'd4, 32'd0);
        write_reg(3'd3, 32'h80);
        high0 = 0;
        for (int i = 0; i < 6; i++) begin
            idle_cycle();
            if (obs_out[7]) high0++;
        end
        checkOutput("len0_width", 32'(high0), 32'd1);

        // PULSE write of zero leaves a running pulse alone
        write_reg(3'd4, 32'd5);
        write_reg(3'd3, 32'h04);
        write_reg(3'd3, 32'h0000_0100);
        read_reg(3'd3);
        checkOutput("pulse0_mask", obs_read, 32'h04);

        // Randomized traffic
        for (int i = 0; i < 700; i++) begin
            case ($urandom_range(0, 9))
                0: idle_cycle();
                1: write_reg(3'd0, $urandom());
                2: write_reg(3'd1, $urandom());
                3: write_reg(3'd2, $urandom());
                4, 5: begin
                    wdata = $urandom() & 32'hFFFF_FF00;
                    if ($urandom_range(0, 3) != 0)
                        wdata = wdata | (32'd1 << $urandom_range(0, 7));
                    write_reg(3'd3, wdata);
                end
                6: write_reg(3'd4, ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 6)));
                7: write_reg(3'd5, $urandom());
                8: write_reg(3'd6, $urandom());
                default: applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                       3'($urandom_range(0, 7)), $urandom());
            endcase
        end

        // Asynchronous reset in the middle of a long pulse
        write_reg(3'd6, 32'd1);
        write_reg(3'd4, 32'd200);
        write_reg(3'd3, 32'h01);
        repeat (100) idle_cycle();
        @(negedge clk);
        #2;
        reset_n    = 1'b0;
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = 3'd5;
        #1;
        checkOutput("async_out_port", 32'(out_port), 32'(RESET_VALUE));
        checkOutput("async_irq", 32'(irq), 32'd0);
        checkOutput("async_status", readdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n    = 1'b1;
        chipselect = 1'b0;
        model_reset();
        repeat (250) idle_cycle();
        read_reg(3'd5);
        checkOutput("post_reset_status", obs_read, 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
